// File: rtl/dot_operand_loader.sv
// rtl/dot_operand_loader.sv - packs N operand pairs, launches the dot-product datapath, returns its result
// Optional short-job support is enabled by defining LOADER_ZERO_PAD_EN.
module dot_operand_loader #(
    parameter int WIDTH = 32,
    parameter int N     = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_last,
    output logic [N*WIDTH-1:0] a_flat,
    output logic [N*WIDTH-1:0] b_flat,
    output logic               start,
    input  logic               dp_valid,
    input  logic               dp_busy,
    input  logic [WIDTH-1:0]   dp_x,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIDTH-1:0]   res_data,
    output logic [15:0]        job_count
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_reg [N];
    logic [WIDTH-1:0] b_reg [N];
    logic [15:0]      job_cnt;
    logic             accept;
    logic             at_end;
    logic             fill_done;

    // Gating with reset keeps the loader silent while a job is being aborted.
    assign in_ready  = (state == FILL) && !reset;
    assign accept    = in_valid && in_ready;
    assign at_end    = (idx == IDX_W'(N - 1));
    assign job_count = job_cnt;

`ifdef LOADER_ZERO_PAD_EN
    assign fill_done = accept && (at_end || in_last);
`else
    logic unused_last;
    assign unused_last = in_last;
    assign fill_done   = accept && at_end;
`endif

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        res_valid = 1'b0;
        case (state)
            FILL: begin
                if (fill_done) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                if (!dp_busy) begin
                    start     = !reset;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (dp_valid) state_nxt = HOLD;
            end
            HOLD: begin
                res_valid = !reset;
                if (res_ready) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FILL;
            idx      <= '0;
            res_data <= '0;
            job_cnt  <= '0;
            for (int i = 0; i < N; i++) begin
                a_reg[i] <= '0;
                b_reg[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (accept) begin
                idx <= fill_done ? '0 : idx + 1'b1;
                for (int i = 0; i < N; i++) begin
                    if (IDX_W'(i) == idx) begin
                        a_reg[i] <= in_a;
                        b_reg[i] <= in_b;
                    end
`ifdef LOADER_ZERO_PAD_EN
                    // A short job clears the unused tail so the datapath sums only given pairs.
                    else if (in_last && (IDX_W'(i) > idx)) begin
                        a_reg[i] <= '0;
                        b_reg[i] <= '0;
                    end
`endif
                end
            end
            if ((state == WAIT) && dp_valid) res_data <= dp_x;
            if ((state == HOLD) && res_ready) job_cnt <= job_cnt + 16'd1;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_flat
        assign a_flat[g*WIDTH +: WIDTH] = a_reg[g];
        assign b_flat[g*WIDTH +: WIDTH] = b_reg[g];
    end
endmodule

// File: tb/tb_dot_operand_loader.sv
// tb/tb_dot_operand_loader.sv - directed and randomized jobs checked against a queue-free operand/sum model
module tb_dot_operand_loader;
    localparam int W = 32;
    localparam int N = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           in_last;
    logic [N*W-1:0] a_flat;
    logic [N*W-1:0] b_flat;
    logic           start;
    logic           dp_valid;
    logic           dp_busy;
    logic [W-1:0]   dp_x;
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   res_data;
    logic [15:0]    job_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int starts = 0;
    logic [15:0] exp_jobs;
    logic [W-1:0] pa [N];
    logic [W-1:0] pb [N];

    dot_operand_loader #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .a_flat(a_flat), .b_flat(b_flat), .start(start),
        .dp_valid(dp_valid), .dp_busy(dp_busy), .dp_x(dp_x),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .job_count(job_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (start) starts = starts + 1;
    end

    task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete job: npairs from pa/pb, optional gaps, datapath busy cycles,
    // datapath latency and result back-pressure. in_last marks pair index 1 when use_last.
    task automatic run_job(input int npairs, input bit gapped, input int busy, input int lat,
                           input int rrh, input bit use_last);
        logic [N*W-1:0] fa;
        logic [N*W-1:0] fb;
        logic [W-1:0]   sum;
        int s0;
        int c0;
        int cs;
        fa = '0;
        fb = '0;
        sum = '0;
        for (int i = 0; i < npairs; i++) begin
            fa[i*W +: W] = pa[i];
            fb[i*W +: W] = pb[i];
            sum = sum + pa[i] * pb[i];
        end
        s0 = starts;
        c0 = 0;
        for (int i = 0; i < npairs; i++) begin
            @(negedge clk);
            if (gapped && ($urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                dp_valid = 1'b1;
                dp_x = $urandom;
                #1;
                chk("in_ready_gap", in_ready, 1);
                @(negedge clk);
                dp_valid = 1'b0;
            end
            in_valid = 1'b1;
            in_a = pa[i];
            in_b = pb[i];
            in_last = use_last && (i == 1);
            if (i == npairs - 1) dp_busy = (busy > 0);
            #1;
            if (i == 0) c0 = cyc;
            chk("in_ready_fill", in_ready, 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
        in_a = $urandom;
        in_b = $urandom;
        #1;
        for (int j = 0; j < busy; j++) begin
            chk("start_while_busy", start, 0);
            chk("in_ready_busy", in_ready, 0);
            @(negedge clk);
            if (j == busy - 1) dp_busy = 1'b0;
            #1;
        end
        cs = cyc;
        chk("start_pulse", start, 1);
        chk("in_ready_launch", in_ready, 0);
        chk("a_flat", a_flat, fa);
        chk("b_flat", b_flat, fb);
        if (!gapped) chk("start_latency", cs - c0, npairs + busy);
        for (int j = 0; j < lat - 1; j++) begin
            @(negedge clk);
            #1;
            chk("start_wait", start, 0);
            chk("res_valid_wait", res_valid, 0);
        end
        @(negedge clk);
        dp_valid = 1'b1;
        dp_x = sum;
        #1;
        chk("res_valid_pre", res_valid, 0);
        @(negedge clk);
        dp_valid = 1'b0;
        dp_x = $urandom;
        #1;
        chk("res_valid", res_valid, 1);
        chk("res_data", res_data, sum);
        chk("start_once", starts - s0, 1);
        for (int j = 0; j < rrh; j++) begin
            @(negedge clk);
            dp_valid = 1'b1;
            dp_x = $urandom;
            #1;
            chk("res_valid_hold", res_valid, 1);
            chk("res_data_hold", res_data, sum);
            chk("in_ready_hold", in_ready, 0);
            chk("ops_hold", a_flat, fa);
        end
        @(negedge clk);
        dp_valid = 1'b0;
        res_ready = 1'b1;
        #1;
        chk("res_valid_hs", res_valid, 1);
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        exp_jobs = exp_jobs + 16'd1;
        chk("in_ready_after", in_ready, 1);
        chk("res_valid_after", res_valid, 0);
        chk("job_count", job_count, exp_jobs);
        chk("start_total", starts - s0, 1);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_last = 1'b0;
        dp_valid = 1'b0;
        dp_busy = 1'b0;
        dp_x = '0;
        res_ready = 1'b0;
        exp_jobs = '0;

        @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_start", start, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_a_flat", a_flat, 0);
        chk("rst_b_flat", b_flat, 0);
        chk("rst_job_count", job_count, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Basic job: (1,2)..(9,10) gives 190.
        for (int i = 0; i < N; i++) begin
            pa[i] = 2 * i + 1;
            pb[i] = 2 * i + 2;
        end
        run_job(N, 1'b0, 0, 3, 0, 1'b0);
        chk("basic_sum", res_data, 190);

        // Backpressure on both sides.
        for (int i = 0; i < N; i++) begin
            pa[i] = $urandom;
            pb[i] = $urandom;
        end
        run_job(N, 1'b0, 4, 2, 10, 1'b0);

        // Gapped input with spurious dp_valid during fill.
        for (int i = 0; i < N; i++) begin
            pa[i] = $urandom_range(0, 1000);
            pb[i] = $urandom_range(0, 1000);
        end
        run_job(N, 1'b1, 0, 1, 2, 1'b0);

        // Reset after three accepts aborts the job.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a = $urandom | 32'h1;
            in_b = $urandom | 32'h1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        begin
            int s_abort;
            s_abort = starts;
            @(negedge clk);
            reset = 1'b0;
            #1;
            chk("midrst_a_flat", a_flat, 0);
            chk("midrst_b_flat", b_flat, 0);
            chk("midrst_idx", dut.idx, 0);
            chk("midrst_in_ready_after", in_ready, 1);
            exp_jobs = '0;
            repeat (3) @(negedge clk);
            #1;
            chk("midrst_no_start", starts - s_abort, 0);
        end
        for (int i = 0; i < N; i++) begin
            pa[i] = $urandom;
            pb[i] = $urandom;
        end
        run_job(N, 1'b0, 0, 2, 0, 1'b0);

`ifdef LOADER_ZERO_PAD_EN
        // Short job: (2,3),(4,5) then zero padding gives 26.
        pa[0] = 2; pb[0] = 3;
        pa[1] = 4; pb[1] = 5;
        run_job(2, 1'b0, 0, 2, 0, 1'b1);
        chk("pad_sum", res_data, 26);
`else
        // in_last has no effect: the job still takes all N pairs.
        for (int i = 0; i < N; i++) begin
            pa[i] = $urandom;
            pb[i] = $urandom;
        end
        run_job(N, 1'b0, 0, 2, 0, 1'b1);
`endif

        // Randomized jobs.
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) begin
                pa[i] = $urandom;
                pb[i] = $urandom;
            end
            run_job(N, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
                    $urandom_range(1, 4), $urandom_range(0, 3), 1'b0);
        end

        // Counter wrap from 0xFFFF.
        @(negedge clk);
        force dut.job_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.job_cnt;
        #1;
        chk("wrap_preload", job_count, 16'hFFFF);
        exp_jobs = 16'hFFFF;
        for (int i = 0; i < N; i++) begin
            pa[i] = $urandom;
            pb[i] = $urandom;
        end
        run_job(N, 1'b0, 0, 1, 0, 1'b0);
        chk("wrap_zero", job_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
